uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/baud_gen.sv | 31 +++
 rtl/uart_tx.sv | 94 +++++++++
 tb/tb_uart_tx.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM state type and default clocking constants
// used by both the transmit and receive sides.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 100_000_000;
    localparam int DEFAULT_BAUD_RATE = 115200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // A divider of 1 still needs a one-bit counter to have a legal vector width.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: pulses bit_tick once every DIV clocks, held at phase zero
// while clear is high so a new frame always starts a full bit period.
module baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = !clear && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit,
// each held for CLK_FREQ/BAUD_RATE clocks.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

    uart_state_t state;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic        bit_tick;
    logic        baud_clear;

    // Timer is parked at zero whenever idle, so the accept edge restarts it.
    assign baud_clear = (state == IDLE);

    baud_gen #(
        .DIV(DIV)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    // The shift register is consumed from bit 0, so tx always takes shreg[0]
    // at a bit boundary and the byte seen on the line is the one captured
    // at accept, regardless of later tx_data activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shreg   <= tx_data;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at DIV=10: line waveforms are compared
// against an ideal 8N1 frame model and decoded by a mid-bit sampling receiver.
module tb_uart_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;
    localparam int FRAME     = 10 * DIV;
    localparam int MAXN      = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int vectors = 0;
    int miscompares = 0;

    logic       cap_tx   [MAXN];
    logic       cap_busy [MAXN];
    logic       cap_done [MAXN];
    logic       exp_q[$];
    logic [7:0] rx_q[$];

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // Ideal line level i cycles into a frame carrying byte b.
    function automatic logic frame_level(input logic [7:0] b, input int i);
        int k;
        k = i / DIV;
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else return 1'b1;
    endfunction

    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < FRAME; i++) exp_q.push_back(frame_level(b, i));
    endtask

    task automatic begin_frame(input logic [7:0] b);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = b;
        @(negedge clk);
    endtask

    task automatic capture(input int n, input int release_at, input int poke_at,
                           input logic [7:0] poke_data, input bit wiggle,
                           input bit send_next, input logic [7:0] next_byte);
        bit pending;
        pending = 1'b0;
        for (int i = 0; i < n; i++) begin
            cap_tx[i]   = tx;
            cap_busy[i] = tx_busy;
            cap_done[i] = tx_done;
            if (i == release_at) tx_start = 1'b0;
            if (i == poke_at) begin
                tx_start = 1'b1;
                tx_data  = poke_data;
            end else if (poke_at >= 0 && i == poke_at + 1) begin
                tx_start = 1'b0;
            end
            if (wiggle) tx_data = 8'($urandom);
            if (send_next && tx_done === 1'b1) begin
                tx_start = 1'b1;
                tx_data  = next_byte;
                pending  = 1'b1;
            end else if (pending && tx_busy === 1'b1) begin
                tx_start = 1'b0;
                pending  = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Mid-bit sampling receiver over the captured line.
    task automatic decode_line(input int n);
        int i;
        logic [7:0] b;
        rx_q.delete();
        i = 0;
        while (i < n) begin
            if (cap_tx[i] === 1'b0 && (i + DIV/2 + 9*DIV) < n) begin
                for (int k = 0; k < 8; k++) b[k] = cap_tx[i + DIV/2 + (k+1)*DIV];
                rx_q.push_back(b);
                i = i + DIV/2 + 9*DIV;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({tx, tx_busy, tx_done} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_async: {tx,busy,done} got %b want 100", {tx, tx_busy, tx_done});
        end
        tx_start = 1'b1;
        tx_data  = 8'($urandom);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({tx, tx_busy, tx_done} !== 3'b100) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: %0d non-idle cycles, want 0", bad);
        end
        reset    = 1'b0;
        tx_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({tx, tx_busy, tx_done} !== 3'b100) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL idle_quiet: %0d non-idle cycles, want 0", bad);
        end
    endtask

    task automatic test_single_55();
        int bad, first, busy_n, done_n;
        begin_frame(8'h55);
        capture(FRAME + 2, 0, -1, 8'h00, 1'b0, 1'b0, 8'h00);
        exp_q.delete();
        push_frame(8'h55);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        bad = 0; first = -1; busy_n = 0; done_n = 0;
        for (int i = 0; i < FRAME + 2; i++) begin
            if (cap_tx[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
            if (cap_busy[i] === 1'b1) busy_n++;
            if (cap_done[i] === 1'b1) done_n++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL wave_55: %0d bad cycles, first at %0d, want 0", bad, first);
        end
        vectors++;
        if (busy_n != FRAME) begin
            miscompares++;
            $display("[TB] FAIL busy_len_55: got %0d cycles want %0d", busy_n, FRAME);
        end
        vectors++;
        if (done_n != 1 || cap_done[FRAME] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL done_55: got %0d pulses (at end %b) want 1", done_n, cap_done[FRAME]);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] b;
        bit wig;
        int bad, busy_n, done_n;
        for (int f = 0; f < 6; f++) begin
            b   = 8'($urandom);
            wig = 1'($urandom);
            begin_frame(b);
            capture(FRAME + 1, 0, -1, 8'h00, wig, 1'b0, 8'h00);
            exp_q.delete();
            push_frame(b);
            exp_q.push_back(1'b1);
            bad = 0; busy_n = 0; done_n = 0;
            for (int i = 0; i < FRAME + 1; i++) begin
                if (cap_tx[i] !== exp_q[i]) bad++;
                if (cap_busy[i] === 1'b1) busy_n++;
                if (cap_done[i] === 1'b1) done_n++;
            end
            vectors++;
            if (bad != 0 || busy_n != FRAME || done_n != 1 || cap_done[FRAME] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rand_frame 0x%02h: bad=%0d busy=%0d done=%0d want 0/%0d/1",
                         b, bad, busy_n, done_n, FRAME);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_busy_ignore();
        int bad, busy_n;
        begin_frame(8'hA3);
        capture(FRAME + DIV + 2, 0, 40, 8'hFF, 1'b0, 1'b0, 8'h00);
        exp_q.delete();
        push_frame(8'hA3);
        for (int i = 0; i < DIV + 2; i++) exp_q.push_back(1'b1);
        bad = 0; busy_n = 0;
        for (int i = 0; i < FRAME + DIV + 2; i++) begin
            if (cap_tx[i] !== exp_q[i]) bad++;
            if (cap_busy[i] === 1'b1) busy_n++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL busy_ignore_wave: %0d bad cycles want 0", bad);
        end
        vectors++;
        if (busy_n != FRAME) begin
            miscompares++;
            $display("[TB] FAIL busy_ignore_len: got %0d busy cycles want %0d", busy_n, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        int bad, done_n, n;
        n = 2*FRAME + 3;
        begin_frame(8'h01);
        tx_data = 8'h80;
        capture(n, FRAME + 1, -1, 8'h00, 1'b0, 1'b0, 8'h00);
        exp_q.delete();
        push_frame(8'h01);
        exp_q.push_back(1'b1);
        push_frame(8'h80);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        bad = 0; done_n = 0;
        for (int i = 0; i < n; i++) begin
            if (cap_tx[i] !== exp_q[i]) bad++;
            if (cap_done[i] === 1'b1) done_n++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_wave: %0d bad cycles want 0", bad);
        end
        vectors++;
        if (cap_busy[FRAME] !== 1'b0 || cap_busy[FRAME+1] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap: busy at gap %b / next %b want 0 / 1",
                     cap_busy[FRAME], cap_busy[FRAME+1]);
        end
        vectors++;
        if (done_n != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_done: got %0d pulses want 2", done_n);
        end
    endtask

    task automatic test_reset_midframe();
        int bad, done_n;
        begin_frame(8'h00);
        capture(35, 0, -1, 8'h00, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        #1;
        vectors++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: tx=%b busy=%b want 1 0", tx, tx_busy);
        end
        done_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) done_n++;
        end
        reset    = 1'b0;
        tx_start = 1'b1;
        tx_data  = 8'h0F;
        @(negedge clk);
        capture(FRAME + 1, 0, -1, 8'h00, 1'b0, 1'b0, 8'h00);
        exp_q.delete();
        push_frame(8'h0F);
        exp_q.push_back(1'b1);
        bad = 0;
        for (int i = 0; i < FRAME + 1; i++) begin
            if (cap_tx[i] !== exp_q[i]) bad++;
            if (i < FRAME && cap_done[i] === 1'b1) done_n++;
        end
        vectors++;
        if (done_n != 0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_done: got %0d stray pulses want 0", done_n);
        end
        vectors++;
        if (bad != 0 || cap_done[FRAME] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL after_reset_0F: %0d bad cycles, done=%b want 0, 1", bad, cap_done[FRAME]);
        end
    endtask

    task automatic test_data_change();
        begin_frame(8'h3C);
        capture(FRAME + 1, 0, -1, 8'h00, 1'b1, 1'b0, 8'h00);
        decode_line(FRAME + 1);
        vectors++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
            miscompares++;
            $display("[TB] FAIL data_change: got %0d bytes, first 0x%02h want 1 byte 0x3C",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_word();
        int n;
        n = 2*FRAME + 4;
        begin_frame(8'h34);
        capture(n, 0, -1, 8'h00, 1'b0, 1'b1, 8'h12);
        decode_line(n);
        vectors++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h34 || rx_q[1] !== 8'h12) begin
            miscompares++;
            $display("[TB] FAIL word_1234: got %0d bytes (0x%02h 0x%02h) want 0x34 0x12", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'hxx, (rx_q.size() > 1) ? rx_q[1] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_single_55();
        test_random_frames();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midframe();
        test_data_change();
        test_word();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
